// File: rtl/corr_pkg.sv
// -----------------------------------------------------------------------------
// corr_pkg
// Shared defaults and types for the template-correlation window engine.
//   - Frame and template geometry, pixel width, frame address width and the
//     fixed read latency of the frame and template memories.
//   - FSM state encoding used by the engine.
//   - const_mul: shift-and-add product of a coordinate and a constant. When
//     the constant is a parameter this reduces to a few adders, so no general
//     multiplier is built on the start row.
// -----------------------------------------------------------------------------
package corr_pkg;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int TW       = 16;
    localparam int TH       = 16;
    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 19;
    localparam int READ_LAT = 2;
    localparam int CORR_W   = 32;
    localparam int COORD_W  = 13;
    localparam int TPL_AW   = $clog2(TW * TH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] const_mul(input logic [COORD_W-1:0] v,
                                              input int unsigned       k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) begin
                acc = acc + (32'(v) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/corr_window_engine_if.sv
// -----------------------------------------------------------------------------
// corr_window_engine_if
// Bundles every non-clock signal of the correlation engine: the scan
// controller handshake (start/coordinates/score/done/busy) and the read
// ports of the frame store and template memory.
//   slave  : the engine side (drives addresses, strobe, score, done, busy)
//   master : the environment side (controller + memories)
// -----------------------------------------------------------------------------
interface corr_window_engine_if #(
    parameter int ADDR_W  = corr_pkg::ADDR_W,
    parameter int PIX_W   = corr_pkg::PIX_W,
    parameter int TPL_AW  = corr_pkg::TPL_AW,
    parameter int COORD_W = corr_pkg::COORD_W,
    parameter int CORR_W  = corr_pkg::CORR_W
);
    // Controller handshake
    logic               iStart;
    logic [COORD_W-1:0] iX;
    logic [COORD_W-1:0] iY;
    logic [CORR_W-1:0]  oCorr;
    logic               oDone;
    logic               oBusy;

    // Frame store read port
    logic [ADDR_W-1:0]  oFrameAddr;
    logic               oFrameRd;
    logic [PIX_W-1:0]   iFrameData;

    // Template memory read port
    logic [TPL_AW-1:0]  oTplAddr;
    logic [PIX_W-1:0]   iTplData;

    modport slave (
        input  iStart, iX, iY, iFrameData, iTplData,
        output oCorr, oDone, oBusy, oFrameAddr, oFrameRd, oTplAddr
    );

    modport master (
        output iStart, iX, iY, iFrameData, iTplData,
        input  oCorr, oDone, oBusy, oFrameAddr, oFrameRd, oTplAddr
    );

endinterface

// File: rtl/corr_mac.sv
// -----------------------------------------------------------------------------
// corr_mac
// Tag-gated multiply register followed by an accumulator.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : clears the accumulator (priority over en_i)
//   en_i      : adds the registered product into the accumulator
//   tag_i     : slot is valid and inside the frame; when low the product is 0
//   pix_a_i   : frame pixel
//   pix_b_i   : template pixel
//   acc_o     : running sum of products
// The product register is loaded every cycle; an untagged slot loads zero, so
// clipped or idle slots never disturb the sum whatever the memories return.
// -----------------------------------------------------------------------------
module corr_mac
    import corr_pkg::*;
#(
    parameter int PIX_W = corr_pkg::PIX_W,
    parameter int ACC_W = CORR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             tag_i,
    input  logic [PIX_W-1:0] pix_a_i,
    input  logic [PIX_W-1:0] pix_b_i,
    output logic [ACC_W-1:0] acc_o
);

    localparam int PROD_W = 2 * PIX_W;

    logic [PROD_W-1:0] prod_q, prod_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (here via the ternaries); a missing branch would infer a latch.
    always_comb begin
        prod_d = tag_i ? (PROD_W'(pix_a_i) * PROD_W'(pix_b_i)) : '0;
        acc_d  = clr_i ? '0 : (en_i ? acc_q + ACC_W'(prod_q) : acc_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/corr_window_engine.sv
// -----------------------------------------------------------------------------
// corr_window_engine
// Unsigned sum-of-products between a TW x TH template and the frame window
// whose top-left corner is (iX, iY). One score and one done pulse per window.
//   iCLK, iRST : clock, asynchronous active-high reset
//   bus        : corr_window_engine_if.slave
//     iStart/iX/iY     start request, accepted only while idle
//     oFrameAddr/Rd    frame read, one slot per ISSUE cycle
//     iFrameData       frame pixel, READ_LAT cycles after the address
//     oTplAddr         template read, ty*TW+tx
//     iTplData         template pixel, READ_LAT cycles after the address
//     oCorr/oDone      score and its one-cycle valid pulse
//     oBusy            high from accept through the done cycle
// Timeline (accept in cycle T): ISSUE T+1..T+N, DRAIN READ_LAT+2 cycles,
// DONE in T+N+READ_LAT+3. Slot k address in cycle k, data k+READ_LAT,
// product k+READ_LAT+1, accumulated k+READ_LAT+2.
// -----------------------------------------------------------------------------
module corr_window_engine
    import corr_pkg::*;
#(
    parameter int H_RES    = corr_pkg::H_RES,
    parameter int V_RES    = corr_pkg::V_RES,
    parameter int TW       = corr_pkg::TW,
    parameter int TH       = corr_pkg::TH,
    parameter int PIX_W    = corr_pkg::PIX_W,
    parameter int ADDR_W   = corr_pkg::ADDR_W,
    parameter int READ_LAT = corr_pkg::READ_LAT
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    corr_window_engine_if.slave   bus
);

    localparam int N         = TW * TH;
    localparam int TX_W      = $clog2(TW);
    localparam int TY_W      = $clog2(TH);
    localparam int TPL_W     = $clog2(N);
    localparam int DRAIN_CYC = READ_LAT + 2;
    localparam int DR_W      = $clog2(DRAIN_CYC + 1);
    localparam int C_W       = COORD_W + 1;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [TX_W-1:0]      tx_q, tx_d;
    logic [TY_W-1:0]      ty_q, ty_d;
    logic [TPL_W-1:0]     tpl_q, tpl_d;
    logic [ADDR_W-1:0]    row_base_q, row_base_d;
    logic [DR_W-1:0]      drain_q, drain_d;
    logic [CORR_W-1:0]    corr_q, corr_d;
    logic [READ_LAT-1:0]  tag_q, tag_d;

    // FSM decoded outputs
    logic busy, done, issuing;

    logic               accept;
    logic [C_W-1:0]     col, row;
    logic               in_frame;
    logic               slot_last;
    logic               drain_last;
    logic [CORR_W-1:0]  acc;

    assign accept = bus.iStart && (state_q == IDLE);

    // Current slot geometry. One extra bit keeps iX+tx from wrapping below
    // the resolution limits.
    assign col        = C_W'(x_q) + C_W'(tx_q);
    assign row        = C_W'(y_q) + C_W'(ty_q);
    assign in_frame   = (col < C_W'(H_RES)) && (row < C_W'(V_RES));
    assign slot_last  = (tx_q == TX_W'(TW - 1)) && (ty_q == TY_W'(TH - 1));
    assign drain_last = (drain_q == DR_W'(DRAIN_CYC - 1));

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = ISSUE;
            ISSUE:   if (slot_last)  state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        issuing = (state_q == ISSUE);
    end

    // ---------------------------------------------------------------------
    // Datapath next state
    // ---------------------------------------------------------------------
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        tpl_d      = tpl_q;
        row_base_d = row_base_q;
        drain_d    = drain_q;
        corr_d     = corr_q;

        if (accept) begin
            x_d        = bus.iX;
            y_d        = bus.iY;
            tx_d       = '0;
            ty_d       = '0;
            tpl_d      = '0;
            row_base_d = ADDR_W'(const_mul(bus.iY, H_RES));
        end else if (issuing && !slot_last) begin
            // Counters stop on the last slot so the addresses hold afterwards.
            tpl_d = tpl_q + 1'b1;
            if (tx_q == TX_W'(TW - 1)) begin
                tx_d       = '0;
                ty_d       = ty_q + 1'b1;
                row_base_d = row_base_q + ADDR_W'(H_RES);
            end else begin
                tx_d = tx_q + 1'b1;
            end
        end

        if (issuing) begin
            drain_d = '0;
        end else if (state_q == DRAIN) begin
            drain_d = drain_q + 1'b1;
        end

        // The last product lands in the accumulator in the final DRAIN cycle,
        // so the score is captured on the edge into DONE.
        if ((state_q == DRAIN) && drain_last) begin
            corr_d = acc;
        end

        // Tag bit for the current slot enters at bit 0; bit READ_LAT-1 lines
        // up with the returning data.
        tag_d = READ_LAT'({tag_q, issuing && in_frame});
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_q        <= '0;
            y_q        <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            tpl_q      <= '0;
            row_base_q <= '0;
            drain_q    <= '0;
            corr_q     <= '0;
            tag_q      <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            tpl_q      <= tpl_d;
            row_base_q <= row_base_d;
            drain_q    <= drain_d;
            corr_q     <= corr_d;
            tag_q      <= tag_d;
        end
    end

    // ---------------------------------------------------------------------
    // Multiply-accumulate
    // ---------------------------------------------------------------------
    corr_mac #(
        .PIX_W (PIX_W),
        .ACC_W (CORR_W)
    ) u_mac (
        .clk     (iCLK),
        .rst     (iRST),
        .clr_i   (accept),
        .en_i    (busy),
        .tag_i   (tag_q[READ_LAT-1]),
        .pix_a_i (bus.iFrameData),
        .pix_b_i (bus.iTplData),
        .acc_o   (acc)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.oFrameAddr = row_base_q + ADDR_W'(col);
    assign bus.oFrameRd   = issuing && in_frame;
    assign bus.oTplAddr   = tpl_q;
    assign bus.oCorr      = corr_q;
    assign bus.oDone      = done;
    assign bus.oBusy      = busy;

endmodule

// File: tb/tb_corr_window_engine.sv
// -----------------------------------------------------------------------------
// tb_corr_window_engine
// Directed bench for corr_window_engine with a READ_LAT-deep frame/template
// memory model. Template pixels are all 1; frame pixels are either all 1 or
// equal to (column & 0xFF).
// -----------------------------------------------------------------------------
module tb_corr_window_engine;
    import corr_pkg::*;

    localparam int RL      = READ_LAT;
    localparam int NSLOT   = TW * TH;
    localparam int LATENCY = NSLOT + RL + 3;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    corr_window_engine_if bus ();

    corr_window_engine dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    // Cycle counter: holds k during cycle k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model
    int frame_mode = 0;
    logic [PIX_W-1:0] fpipe [RL];
    logic [PIX_W-1:0] tpipe [RL];

    function automatic logic [PIX_W-1:0] frame_pix(input logic [ADDR_W-1:0] a);
        if (frame_mode == 1) return PIX_W'(a % ADDR_W'(H_RES));
        return PIX_W'(1);
    endfunction

    always @(posedge clk) begin
        fpipe[0] <= frame_pix(bus.oFrameAddr);
        tpipe[0] <= PIX_W'(1);
        for (int i = 1; i < RL; i++) begin
            fpipe[i] <= fpipe[i-1];
            tpipe[i] <= tpipe[i-1];
        end
    end

    assign bus.iFrameData = fpipe[RL-1];
    assign bus.iTplData   = tpipe[RL-1];

    // Monitor
    int acc_cyc = -100000;
    int win_x, win_y;
    int rd_cnt, addr_err, tpl_err, done_cnt;

    always @(negedge clk) begin
        int s;
        logic [ADDR_W-1:0] ea;
        s  = cyc - acc_cyc - 1;
        ea = ADDR_W'((win_y + s / TW) * H_RES + win_x + s % TW);
        if (bus.oFrameRd) begin
            rd_cnt++;
            if (s < 0 || s >= NSLOT || bus.oFrameAddr !== ea) addr_err++;
        end
        if (s >= 0 && s < NSLOT && bus.oTplAddr !== TPL_AW'(s)) tpl_err++;
        if (bus.oDone) done_cnt++;
    end

    // Checking
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_window(input int x, input int y);
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iX     = COORD_W'(x);
        bus.iY     = COORD_W'(y);
        win_x      = x;
        win_y      = y;
        acc_cyc    = cyc;
        rd_cnt     = 0;
        addr_err   = 0;
        tpl_err    = 0;
        done_cnt   = 0;
        @(negedge clk);
        bus.iStart = 1'b0;
    endtask

    // Waits for oDone (bounded) and checks the window's results; returns 1ns
    // after the negedge of the DONE cycle.
    task automatic finish_window(input string tag, input int exp_corr, input int exp_rd);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * LATENCY; k++) begin
            @(negedge clk);
            if (bus.oDone) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(LATENCY));
        check({tag, "_corr"}, bus.oCorr, 32'(exp_corr));
        check({tag, "_busy_at_done"}, 32'(bus.oBusy), 32'd1);
        check({tag, "_rd_count"}, 32'(rd_cnt), 32'(exp_rd));
        check({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        check({tag, "_tpl_err"}, 32'(tpl_err), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        bus.iStart = 1'b0;
        bus.iX     = '0;
        bus.iY     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_corr", bus.oCorr, 32'd0);
        check("rst_done", 32'(bus.oDone), 32'd0);
        check("rst_busy", 32'(bus.oBusy), 32'd0);
        check("rst_frd", 32'(bus.oFrameRd), 32'd0);
        check("rst_faddr", 32'(bus.oFrameAddr), 32'd0);
        check("rst_taddr", 32'(bus.oTplAddr), 32'd0);
        rst = 1'b0;

        // 1: all ones, interior window
        frame_mode = 0;
        start_window(100, 100);
        finish_window("t1", 256, 256);

        // 2: frame = column, started in the cycle right after the previous done
        frame_mode = 1;
        start_window(0, 0);
        finish_window("t2", 1920, 256);

        // 3: right edge clips 8 columns
        frame_mode = 0;
        start_window(632, 100);
        finish_window("t3", 128, 128);

        // 4: fully outside
        start_window(640, 480);
        finish_window("t4", 0, 0);

        // 5: starts during ISSUE and during DONE are ignored
        start_window(100, 100);
        repeat (50) @(negedge clk);
        bus.iStart = 1'b1;
        bus.iX     = COORD_W'(632);
        bus.iY     = COORD_W'(100);
        @(negedge clk);
        bus.iStart = 1'b0;
        finish_window("t5", 256, 256);
        bus.iStart = 1'b1;
        bus.iX     = '0;
        bus.iY     = '0;
        @(negedge clk);
        bus.iStart = 1'b0;
        #1;
        check("t5_idle_after_done", 32'(bus.oBusy), 32'd0);
        repeat (LATENCY + 40) @(negedge clk);
        #1;
        check("t5_single_done", 32'(done_cnt), 32'd1);
        check("t5_no_extra_reads", 32'(rd_cnt), 32'd256);
        check("t5_corr_held", bus.oCorr, 32'd256);

        // 6: reset mid-ISSUE aborts the window
        start_window(100, 100);
        repeat (100) @(negedge clk);
        rst     = 1'b1;
        acc_cyc = -100000;
        @(posedge clk);
        #1;
        check("t6_rst_busy", 32'(bus.oBusy), 32'd0);
        check("t6_rst_frd", 32'(bus.oFrameRd), 32'd0);
        check("t6_rst_corr", bus.oCorr, 32'd0);
        check("t6_rst_faddr", 32'(bus.oFrameAddr), 32'd0);
        check("t6_rst_taddr", 32'(bus.oTplAddr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LATENCY + 40) @(negedge clk);
        #1;
        check("t6_no_done", 32'(done_cnt), 32'd0);
        start_window(100, 100);
        finish_window("t6_restart", 256, 256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
